// File: rtl/edit_campo_hora.sv
// Time-field editor: tracks live RTC seconds/minutes/hours, applies BCD up/down
// edits to the field chosen by dir, and hands the result back over a req/ack.
//
// state  | meaning
// TRACK  | fields follow seg_in/min_in/hora_in every clk
// EDIT   | arriba/abajo modify the field selected by dir
// COMMIT | fields frozen, wr_req held until wr_ack is sampled
module edit_campo_hora #(
  parameter logic [7:0] HORA_MAX = 8'h23,
  parameter logic [7:0] MS_MAX   = 8'h59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] dir,
  input  logic       arriba,
  input  logic       abajo,
  input  logic [7:0] seg_in,
  input  logic [7:0] min_in,
  input  logic [7:0] hora_in,
  input  logic       wr_ack,
  output logic [7:0] seg_out,
  output logic [7:0] min_out,
  output logic [7:0] hora_out,
  output logic       wr_req,
  output logic       editando
);

  typedef enum logic [1:0] {
    TRACK  = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state;

  // Any digit above 9 is treated as out of range, so it wraps like v > max.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] maxv);
    logic [7:0] r;
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v >= maxv)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = v + 8'd1;
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] maxv);
    logic [7:0] r;
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v == 8'h00 || v > maxv)
      r = maxv;
    else if (v[3:0] == 4'd0)
      r = {v[7:4] - 4'd1, 4'd9};
    else
      r = v - 8'd1;
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= TRACK;
      seg_out  <= 8'h00;
      min_out  <= 8'h00;
      hora_out <= 8'h00;
      wr_req   <= 1'b0;
      editando <= 1'b0;
    end else begin
      case (state)
        TRACK: begin
          seg_out  <= seg_in;
          min_out  <= min_in;
          hora_out <= hora_in;
          if (en) begin
            state    <= EDIT;
            editando <= 1'b1;
          end
        end
        EDIT: begin
          if (!en) begin
            state    <= COMMIT;
            wr_req   <= 1'b1;
            editando <= 1'b0;
          end else if (arriba ^ abajo) begin
            case (dir)
              2'b00:   seg_out  <= arriba ? bcd_inc(seg_out, MS_MAX)    : bcd_dec(seg_out, MS_MAX);
              2'b01:   min_out  <= arriba ? bcd_inc(min_out, MS_MAX)    : bcd_dec(min_out, MS_MAX);
              2'b10:   hora_out <= arriba ? bcd_inc(hora_out, HORA_MAX) : bcd_dec(hora_out, HORA_MAX);
              default: ;
            endcase
          end
        end
        COMMIT: begin
          if (wr_ack) begin
            wr_req <= 1'b0;
            state  <= TRACK;
          end
        end
        default: begin
          state    <= TRACK;
          wr_req   <= 1'b0;
          editando <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edit_campo_hora.sv
// Self-checking bench for edit_campo_hora: directed vector table, randomized
// run against a decimal-arithmetic reference model, and async-reset corners.
module tb_edit_campo_hora;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] dir;
  logic       arriba, abajo, wr_ack;
  logic [7:0] seg_in, min_in, hora_in;
  logic [7:0] seg_out, min_out, hora_out;
  logic       wr_req, editando;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  edit_campo_hora dut (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .arriba(arriba), .abajo(abajo),
    .seg_in(seg_in), .min_in(min_in), .hora_in(hora_in), .wr_ack(wr_ack),
    .seg_out(seg_out), .min_out(min_out), .hora_out(hora_out),
    .wr_req(wr_req), .editando(editando)
  );

  // ---------------- reference model (decimal arithmetic) ----------------
  localparam logic [7:0] H_MAX = 8'h23;
  localparam logic [7:0] M_MAX = 8'h59;

  int         m_mode;  // 0 tracking, 1 editing, 2 waiting for ack
  logic [7:0] m_seg, m_min, m_hora;
  logic       m_req;

  function automatic bit bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic int to_dec(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  function automatic logic [7:0] ref_inc(input logic [7:0] v, input logic [7:0] mx);
    if (!bcd_ok(v) || to_dec(v) >= to_dec(mx)) return 8'h00;
    return to_bcd(to_dec(v) + 1);
  endfunction

  function automatic logic [7:0] ref_dec(input logic [7:0] v, input logic [7:0] mx);
    if (!bcd_ok(v) || to_dec(v) == 0 || to_dec(v) > to_dec(mx)) return mx;
    return to_bcd(to_dec(v) - 1);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_seg = 8'h00; m_min = 8'h00; m_hora = 8'h00; m_req = 1'b0;
  endtask

  task automatic model_step();
    if (m_mode == 0) begin
      m_seg = seg_in; m_min = min_in; m_hora = hora_in;
      if (en) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!en) begin
        m_mode = 2; m_req = 1'b1;
      end else if (arriba != abajo) begin
        if (dir == 2'd0) m_seg  = arriba ? ref_inc(m_seg, M_MAX)  : ref_dec(m_seg, M_MAX);
        if (dir == 2'd1) m_min  = arriba ? ref_inc(m_min, M_MAX)  : ref_dec(m_min, M_MAX);
        if (dir == 2'd2) m_hora = arriba ? ref_inc(m_hora, H_MAX) : ref_dec(m_hora, H_MAX);
      end
    end else if (wr_ack) begin
      m_mode = 0; m_req = 1'b0;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] es, input logic [7:0] em,
                         input logic [7:0] eh, input logic er, input logic ee);
    chk({tag, " seg"},  seg_out,  es);
    chk({tag, " min"},  min_out,  em);
    chk({tag, " hora"}, hora_out, eh);
    chk({tag, " req"},  {7'd0, wr_req},   {7'd0, er});
    chk({tag, " edit"}, {7'd0, editando}, {7'd0, ee});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic e, input logic [1:0] d, input logic up, input logic dn,
                       input logic ack, input logic [7:0] s, input logic [7:0] m,
                       input logic [7:0] h);
    en = e; dir = d; arriba = up; abajo = dn; wr_ack = ack;
    seg_in = s; min_in = m; hora_in = h;
  endtask

  // called at posedge+1; asserts reset mid-cycle, releases it at negedge
  task automatic do_reset(input string tag);
    reset = 1'b1;
    model_reset();
    #1;
    chk_all(tag, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    #3;
    reset = 1'b0;
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       e;
    logic [1:0] d;
    logic       up, dn, ack;
    logic [7:0] si, mi, hi;
    logic [7:0] es, em, eh;
    logic       er, ee;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic e, input logic [1:0] d, input logic up, input logic dn,
                     input logic ack, input logic [7:0] si, input logic [7:0] mi,
                     input logic [7:0] hi, input logic [7:0] es, input logic [7:0] em,
                     input logic [7:0] eh, input logic er, input logic ee);
    vec_t v;
    v.e = e; v.d = d; v.up = up; v.dn = dn; v.ack = ack;
    v.si = si; v.mi = mi; v.hi = hi;
    v.es = es; v.em = em; v.eh = eh; v.er = er; v.ee = ee;
    tbl.push_back(v);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    model_reset();
    #3;
    chk_all("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    //   en dir up dn ack  seg_in min_in hora_in  -> seg   min   hora  req edit
    add(0, 2'd0, 0, 0, 0, 8'h42, 8'h17, 8'h09,   8'h42, 8'h17, 8'h09, 0, 0);
    add(0, 2'd0, 1, 0, 0, 8'h58, 8'h17, 8'h09,   8'h58, 8'h17, 8'h09, 0, 0);
    add(1, 2'd0, 0, 0, 0, 8'h58, 8'h17, 8'h09,   8'h58, 8'h17, 8'h09, 0, 1);
    add(1, 2'd0, 1, 0, 0, 8'h11, 8'h11, 8'h11,   8'h59, 8'h17, 8'h09, 0, 1);
    add(1, 2'd0, 1, 0, 0, 8'h11, 8'h11, 8'h11,   8'h00, 8'h17, 8'h09, 0, 1);
    add(1, 2'd0, 1, 0, 0, 8'h11, 8'h11, 8'h11,   8'h01, 8'h17, 8'h09, 0, 1);
    add(1, 2'd2, 0, 1, 0, 8'h11, 8'h11, 8'h11,   8'h01, 8'h17, 8'h08, 0, 1);
    add(1, 2'd2, 1, 1, 0, 8'h11, 8'h11, 8'h11,   8'h01, 8'h17, 8'h08, 0, 1);
    add(1, 2'd3, 1, 0, 0, 8'h11, 8'h11, 8'h11,   8'h01, 8'h17, 8'h08, 0, 1);
    add(1, 2'd1, 1, 0, 0, 8'h11, 8'h11, 8'h11,   8'h01, 8'h18, 8'h08, 0, 1);
    add(0, 2'd1, 1, 0, 0, 8'h11, 8'h11, 8'h11,   8'h01, 8'h18, 8'h08, 1, 0);
    add(1, 2'd1, 1, 0, 0, 8'h11, 8'h11, 8'h11,   8'h01, 8'h18, 8'h08, 1, 0);
    add(0, 2'd0, 0, 1, 0, 8'h11, 8'h11, 8'h11,   8'h01, 8'h18, 8'h08, 1, 0);
    add(1, 2'd2, 1, 0, 0, 8'h11, 8'h11, 8'h11,   8'h01, 8'h18, 8'h08, 1, 0);
    add(0, 2'd0, 0, 0, 0, 8'h11, 8'h11, 8'h11,   8'h01, 8'h18, 8'h08, 1, 0);
    add(0, 2'd0, 0, 0, 1, 8'h11, 8'h11, 8'h11,   8'h01, 8'h18, 8'h08, 0, 0);
    add(0, 2'd0, 1, 0, 1, 8'h30, 8'h45, 8'h00,   8'h30, 8'h45, 8'h00, 0, 0);
    add(1, 2'd2, 0, 0, 1, 8'h30, 8'h45, 8'h00,   8'h30, 8'h45, 8'h00, 0, 1);
    add(1, 2'd2, 0, 1, 0, 8'h99, 8'h99, 8'h99,   8'h30, 8'h45, 8'h23, 0, 1);
    add(1, 2'd2, 0, 1, 0, 8'h99, 8'h99, 8'h99,   8'h30, 8'h45, 8'h22, 0, 1);
    add(1, 2'd0, 0, 1, 0, 8'h99, 8'h99, 8'h99,   8'h29, 8'h45, 8'h22, 0, 1);
    add(1, 2'd1, 1, 0, 0, 8'h99, 8'h99, 8'h99,   8'h29, 8'h46, 8'h22, 0, 1);
    add(0, 2'd1, 0, 0, 0, 8'h99, 8'h99, 8'h99,   8'h29, 8'h46, 8'h22, 1, 0);
    add(0, 2'd1, 0, 0, 1, 8'h99, 8'h99, 8'h99,   8'h29, 8'h46, 8'h22, 0, 0);
    add(0, 2'd0, 0, 0, 0, 8'h10, 8'h59, 8'h10,   8'h10, 8'h59, 8'h10, 0, 0);
    add(1, 2'd0, 0, 0, 0, 8'h10, 8'h59, 8'h10,   8'h10, 8'h59, 8'h10, 0, 1);
    add(1, 2'd2, 0, 1, 0, 8'h10, 8'h59, 8'h10,   8'h10, 8'h59, 8'h09, 0, 1);
    add(1, 2'd1, 1, 0, 0, 8'h10, 8'h59, 8'h10,   8'h10, 8'h00, 8'h09, 0, 1);
    add(1, 2'd1, 0, 1, 0, 8'h10, 8'h59, 8'h10,   8'h10, 8'h59, 8'h09, 0, 1);
    add(1, 2'd0, 0, 1, 0, 8'h10, 8'h59, 8'h10,   8'h09, 8'h59, 8'h09, 0, 1);
    add(0, 2'd0, 0, 0, 0, 8'h10, 8'h59, 8'h10,   8'h09, 8'h59, 8'h09, 1, 0);
    add(0, 2'd0, 0, 0, 1, 8'h10, 8'h59, 8'h10,   8'h09, 8'h59, 8'h09, 0, 0);
    add(0, 2'd0, 0, 0, 0, 8'h5A, 8'h3F, 8'h24,   8'h5A, 8'h3F, 8'h24, 0, 0);
    add(1, 2'd0, 0, 0, 0, 8'h5A, 8'h3F, 8'h24,   8'h5A, 8'h3F, 8'h24, 0, 1);
    add(1, 2'd0, 1, 0, 0, 8'h5A, 8'h3F, 8'h24,   8'h00, 8'h3F, 8'h24, 0, 1);
    add(1, 2'd1, 0, 1, 0, 8'h5A, 8'h3F, 8'h24,   8'h00, 8'h59, 8'h24, 0, 1);
    add(1, 2'd2, 1, 0, 0, 8'h5A, 8'h3F, 8'h24,   8'h00, 8'h59, 8'h00, 0, 1);
    add(1, 2'd2, 0, 1, 0, 8'h5A, 8'h3F, 8'h24,   8'h00, 8'h59, 8'h23, 0, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].e, tbl[i].d, tbl[i].up, tbl[i].dn, tbl[i].ack, tbl[i].si, tbl[i].mi, tbl[i].hi);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].es, tbl[i].em, tbl[i].eh, tbl[i].er, tbl[i].ee);
    end

    // ---------------- randomized run against the model ----------------
    do_reset("rand reset");
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] r [3];
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 3) == 0) r[k] = 8'($urandom);
        else r[k] = to_bcd(int'($urandom_range(0, (k == 2) ? 25 : 61)));
      end
      if ($urandom_range(0, 7) == 0) en = ~en;
      dir    = 2'($urandom_range(0, 3));
      arriba = ($urandom_range(0, 2) == 0);
      abajo  = ($urandom_range(0, 2) == 0);
      wr_ack = ($urandom_range(0, 3) == 0);
      seg_in = r[0]; min_in = r[1]; hora_in = r[2];
      tick();
      chk_all($sformatf("rand%0d", n), m_seg, m_min, m_hora, m_req, (m_mode == 1));
    end

    // ---------------- async reset during COMMIT ----------------
    do_reset("pre reset");
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h11, 8'h22, 8'h03);
    tick();
    drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'h11, 8'h22, 8'h03);
    tick();
    drive(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 8'h11, 8'h22, 8'h03);
    tick();
    drive(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'h11, 8'h22, 8'h03);
    tick();
    chk_all("commit", 8'h11, 8'h23, 8'h03, 1'b1, 1'b0);
    do_reset("reset in commit");
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h44, 8'h33, 8'h12);
    tick();
    chk_all("track after reset", 8'h44, 8'h33, 8'h12, 1'b0, 1'b0);

    // ---------------- async reset during EDIT ----------------
    drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'h44, 8'h33, 8'h12);
    tick();
    drive(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 8'h44, 8'h33, 8'h12);
    tick();
    chk_all("edit", 8'h45, 8'h33, 8'h12, 1'b0, 1'b1);
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h07, 8'h08, 8'h09);
    do_reset("reset in edit");
    tick();
    chk_all("track after edit reset", 8'h07, 8'h08, 8'h09, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, %0d failed so far", failed);
    $fatal(1, "timeout");
  end

endmodule
